// File: rtl/uart_tx_9bit.sv
// 9-bit UART transmitter: start, 9 data bits LSB first, optional even parity, stop.
// Define UART_TX_PARITY_EN to add the even-parity bit between data and stop.
module uart_tx_9bit #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [8:0] d,
  output logic       tx,
  output logic       busy,
  output logic       done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  logic [8:0]  shift;
  logic [15:0] cnt;
  logic [3:0]  bit_idx;
`ifdef UART_TX_PARITY_EN
  logic        parity;
`endif

  // tx, busy and done are registered and updated on the same edge as the
  // state change, so each bit occupies exactly CLKS_PER_BIT cycles on the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      shift   <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shift   <= d;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
`ifdef UART_TX_PARITY_EN
            parity  <= ^d;
`endif
          end
        end
        START: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            shift <= {1'b0, shift[8:1]};
            if (bit_idx == 4'd8) begin
              bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
              tx      <= parity;
              state   <= PARITY;
`else
              tx      <= 1'b1;
              state   <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`endif
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_9bit.sv
// Directed bench for uart_tx_9bit with CLKS_PER_BIT=4; slot s is the value
// seen after the (s-1)th edge following the load edge (edge 0).
module tb_uart_tx_9bit;

  localparam int N = 4;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int F = PAR ? 12 : 11;
  localparam int P = F * N + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [8:0] d;
  logic       tx;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  uart_tx_9bit #(.CLKS_PER_BIT(N)) dut (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .d     (d),
    .tx    (tx),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Expected line level for slot s of a frame carrying w.
  function automatic logic exp_tx(input logic [8:0] w, input int s);
    int b;
    if (s < 1 || s > F * N) return 1'b1;
    b = (s - 1) / N;
    if (b == 0) return 1'b0;
    if (b <= 9) return w[b-1];
    if (PAR && b == 10) return ^w;
    return 1'b1;
  endfunction

  function automatic logic exp_busy(input int s);
    return (s >= 1 && s <= F * N);
  endfunction

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; d = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: tx/busy/done=%b%b%b want 100", i, tx, busy, done);
      end
    end
  endtask

  task automatic test_frame(input logic [8:0] w);
    int dones = 0;
    load = 1'b1; d = w;
    for (int s = 1; s <= P; s++) begin
      @(negedge clk);
      if (s == 1) begin load = 1'b0; d = ~w; end
      checks++;
      if (tx !== exp_tx(w, s) || busy !== exp_busy(s) || done !== (s == P)) begin
        errors++;
        $display("FAIL frame_%h slot %0d: tx/busy/done=%b%b%b want %b%b%b",
                 w, s, tx, busy, done, exp_tx(w, s), exp_busy(s), s == P);
      end
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL frame_%h_done_count got %0d want 1", w, dones);
    end
  endtask

  task automatic test_load_ignored();
    logic [8:0] w = 9'h1A5;
    int dones = 0;
    load = 1'b1; d = w;
    for (int s = 1; s <= P + 10; s++) begin
      @(negedge clk);
      if (s == 1) load = 1'b0;
      if (s == 20) begin load = 1'b1; d = 9'h000; end
      if (s == 21) load = 1'b0;
      if (s > 21 && s < F * N) d = 9'($urandom_range(0, 511));
      checks++;
      if (tx !== exp_tx(w, s) || busy !== exp_busy(s) || done !== (s == P)) begin
        errors++;
        $display("FAIL load_ignored slot %0d: tx/busy/done=%b%b%b want %b%b%b",
                 s, tx, busy, done, exp_tx(w, s), exp_busy(s), s == P);
      end
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL load_ignored_done_count got %0d want 1", dones);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] w = 9'h0FF;
    int loc;
    int waited = 0;
    load = 1'b1; d = w;
    for (int s = 1; s <= 2 * P + 1; s++) begin
      @(negedge clk);
      loc = ((s - 1) % P) + 1;
      checks++;
      if (tx !== exp_tx(w, loc) || busy !== exp_busy(loc) || done !== (loc == P)) begin
        errors++;
        $display("FAIL back_to_back slot %0d: tx/busy/done=%b%b%b want %b%b%b",
                 s, tx, busy, done, exp_tx(w, loc), exp_busy(loc), loc == P);
      end
    end
    load = 1'b0;
    while (done !== 1'b1 && waited < P + 5) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_drain timeout after %0d cycles, done=%b want 1", waited, done);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] w = 9'h1A5;
    load = 1'b1; d = w;
    for (int s = 1; s <= 15; s++) begin
      @(negedge clk);
      if (s == 1) load = 1'b0;
      checks++;
      if (tx !== exp_tx(w, s) || busy !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_pre slot %0d: tx/busy=%b%b want %b1", s, tx, busy, exp_tx(w, s));
      end
    end
    reset = 1'b1; load = 1'b1;
    @(negedge clk);
    reset = 1'b0; load = 1'b0;
    checks++;
    if ({tx, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_abort: tx/busy/done=%b%b%b want 100", tx, busy, done);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      checks++;
      if ({tx, busy, done} !== 3'b100) begin
        errors++;
        $display("FAIL reset_mid_quiet cycle %0d: tx/busy/done=%b%b%b want 100", i, tx, busy, done);
      end
    end
    test_frame(9'h0A3);
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_frame(9'h1A5);
    test_frame(9'h003);
    test_frame(9'h100);
    test_load_ignored();
    test_back_to_back();
    @(negedge clk);
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
